lockstep_req_checker: RTL and testbench
=======================================

# lockstep_req_checker

Request-side checker that sits directly upstream of the lockstep control peripheral, between the main and shadow cores and the peripheral's single req/gnt/r_valid slave port. It compares the two cores' requests field by field and forwards one request downstream only when they agree. It broadcasts the response back to both cores, and it reports divergences (field mismatch or excessive request skew) as a pulse, a sticky error and a saturating count. With lockstep disabled it is a one-entry registered pass-through for the main core.

## Interface
- ID_WIDTH, 5, transaction ID width on all ports
- SKEW_MAX, 2, max cycles one core may request alone before mismatch (>=1)
- CNT_WIDTH, 8, mismatch counter width
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- enable_i  in  1  lockstep enable (ctrl register bit 0); sampled only in IDLE
- clear_i  in  1  clears error_o and mismatch_cnt_o
- m_req_i, m_addr_i[31:0], m_wen_i, m_wdata_i[31:0], m_be_i[3:0], m_id_i[ID_WIDTH-1:0]  in  main core request; wen=0 is write
- m_gnt_o  out  1  main request accepted
- m_r_valid_o, m_r_opc_o, m_r_id_o[ID_WIDTH-1:0], m_r_rdata_o[31:0]  out  main core response
- s_* (same set as m_*)  shadow core request/response
- p_req_o, p_addr_o[31:0], p_wen_o, p_wdata_o[31:0], p_be_o[3:0], p_id_o[ID_WIDTH-1:0]  out  peripheral request, all registered
- p_gnt_i  in  1  peripheral grant
- p_r_valid_i, p_r_opc_i, p_r_id_i[ID_WIDTH-1:0], p_r_rdata_i[31:0]  in  peripheral response
- mismatch_o  out  1  one-cycle pulse per detected divergence
- error_o  out  1  sticky divergence flag
- mismatch_cnt_o  out  CNT_WIDTH  saturating divergence count

## Operation
- States: IDLE, ISSUE, WAIT_RSP, ERR_RSP.
- IDLE, enable_i=0: on m_req_i, capture main fields. Pulse m_gnt_o the same cycle and go to ISSUE. Shadow port is ignored: s_gnt_o=0, s_r_valid_o=0.
- IDLE, enable_i=1, both req high:
  - Compare addr, wen and be. Compare wdata only when wen=0. IDs are never compared.
  - Equal: capture main fields plus both IDs, pulse m_gnt_o and s_gnt_o, go to ISSUE.
  - Unequal: record a mismatch, capture both IDs, pulse both gnts, go to ERR_RSP. Nothing is forwarded.
- IDLE, enable_i=1, exactly one req high:
  - skew_cnt increments each cycle.
  - When skew_cnt reaches SKEW_MAX with still one req high: record a mismatch, grant only the requesting core, go to ERR_RSP.
  - skew_cnt clears whenever neither or both reqs are high, and on leaving IDLE.
- ISSUE: p_req_o=1 with captured fields; p_id_o is the main ID. On p_gnt_i, go to WAIT_RSP.
- WAIT_RSP: on p_r_valid_i, drive r_valid/opc/rdata combinationally to the main core and, if lockstep was enabled at capture, to the shadow core. Each core receives its own captured ID on r_id. Return to IDLE.
- ERR_RSP: one cycle of r_valid=1, r_opc=1, r_rdata=0, own ID, to each core that was granted. Return to IDLE.
- Recording a mismatch:
  - mismatch_o=1 for one cycle.
  - error_o is set.
  - mismatch_cnt_o increments and saturates at all-ones.
  - clear_i clears error_o and the counter. If clear_i and a mismatch occur in the same cycle, the result is error_o=1 and count=1.

## Timing
- Reset (rst_i=1 at a clock edge) puts the block in IDLE and sets skew_cnt=0.
- Every output is 0 after reset, including all gnt, r_valid, p_* , mismatch_o, error_o and mismatch_cnt_o.
- Reset applied mid-transaction abandons the transaction; no response is generated.
- Gnt is a pulse in the capture cycle T. p_req_o is asserted from T+1 and held until p_gnt_i.
- Best case: request at T, p_gnt_i at T+1, p_r_valid_i at T+2, core r_valid at T+2.
- Mismatch detected at T: mismatch_o at T+1 (registered), error response at T+1.
- A new request is accepted only in IDLE; at most one transaction is outstanding.
- p_gnt_i and p_r_valid_i are ignored outside ISSUE and WAIT_RSP respectively.

## Test plan
- enable=0, main write addr=0x10202800 wdata=0xA5A5A5A5 -> one p_req_o with the same fields at T+1; main r_valid when p_r_valid_i arrives; shadow sees no gnt or r_valid.
- enable=1, identical reads from both cores (m_id=3, s_id=7) -> exactly one p_req_o with p_id_o=3; both cores get the same r_rdata, m_r_id=3, s_r_id=7; mismatch_o stays 0.
- enable=1, writes differing only in wdata (0x1 vs 0x2) -> no p_req_o; both cores get r_opc=1 with r_rdata=0; mismatch_o pulses; error_o=1; count=1.
- enable=1, SKEW_MAX=2: shadow req 1 cycle late -> normal forward. Shadow req 3 cycles late -> main alone gets an error response; count increments.
- 256 forced mismatches with CNT_WIDTH=8 -> count holds 0xFF. Then clear_i together with a mismatch -> count=1, error_o=1.
- rst_i pulsed while in WAIT_RSP -> all outputs 0 the next cycle; a subsequent p_r_valid_i is ignored; the next request is handled normally.

Source files
------------

// File: rtl/lockstep_req_checker.sv
// lockstep_req_checker
// Sits between the main/shadow cores and the single req/gnt/r_valid slave port of the
// lockstep control peripheral. With lockstep enabled it compares both cores' requests
// and forwards one request only when they agree. It broadcasts the response to both
// cores, and it reports divergences (field mismatch or excessive skew) as a pulse, a
// sticky flag and a saturating count. With lockstep disabled it is a one-entry
// registered pass-through for the main core.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                lockstep enable, sampled only while idle
//   clear_i                 clears error_o and mismatch_cnt_o
//   m_* / s_*               main / shadow core request in, gnt and response out
//   p_*                     peripheral request out (registered), gnt and response in
//   mismatch_o              one-cycle pulse per divergence
//   error_o                 sticky divergence flag
//   mismatch_cnt_o          saturating divergence count
module lockstep_req_checker #(
  parameter int unsigned ID_WIDTH  = 5,
  parameter int unsigned SKEW_MAX  = 2,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  // main core
  input  logic                 m_req_i,
  input  logic [31:0]          m_addr_i,
  input  logic                 m_wen_i,
  input  logic [31:0]          m_wdata_i,
  input  logic [3:0]           m_be_i,
  input  logic [ID_WIDTH-1:0]  m_id_i,
  output logic                 m_gnt_o,
  output logic                 m_r_valid_o,
  output logic                 m_r_opc_o,
  output logic [ID_WIDTH-1:0]  m_r_id_o,
  output logic [31:0]          m_r_rdata_o,
  // shadow core
  input  logic                 s_req_i,
  input  logic [31:0]          s_addr_i,
  input  logic                 s_wen_i,
  input  logic [31:0]          s_wdata_i,
  input  logic [3:0]           s_be_i,
  input  logic [ID_WIDTH-1:0]  s_id_i,
  output logic                 s_gnt_o,
  output logic                 s_r_valid_o,
  output logic                 s_r_opc_o,
  output logic [ID_WIDTH-1:0]  s_r_id_o,
  output logic [31:0]          s_r_rdata_o,
  // peripheral
  output logic                 p_req_o,
  output logic [31:0]          p_addr_o,
  output logic                 p_wen_o,
  output logic [31:0]          p_wdata_o,
  output logic [3:0]           p_be_o,
  output logic [ID_WIDTH-1:0]  p_id_o,
  input  logic                 p_gnt_i,
  input  logic                 p_r_valid_i,
  input  logic                 p_r_opc_i,
  input  logic [ID_WIDTH-1:0]  p_r_id_i,
  input  logic [31:0]          p_r_rdata_i,
  // status
  output logic                 mismatch_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] mismatch_cnt_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StIssue   = 2'd1;
  localparam logic [1:0] StWaitRsp = 2'd2;
  localparam logic [1:0] StErrRsp  = 2'd3;

  localparam int unsigned SkewW = $clog2(SKEW_MAX + 1);

  logic [1:0]           state_q, state_d;
  logic [SkewW-1:0]     skew_q, skew_d;
  logic                 m_granted_q, m_granted_d;
  logic                 s_granted_q, s_granted_d;
  logic [ID_WIDTH-1:0]  m_id_q, m_id_d;
  logic [ID_WIDTH-1:0]  s_id_q, s_id_d;
  logic                 p_req_q, p_req_d;
  logic [31:0]          p_addr_q, p_addr_d;
  logic                 p_wen_q, p_wen_d;
  logic [31:0]          p_wdata_q, p_wdata_d;
  logic [3:0]           p_be_q, p_be_d;
  logic [ID_WIDTH-1:0]  p_id_q, p_id_d;
  logic                 mismatch_q;
  logic                 error_q, error_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic fields_equal;
  logic mismatch_event;
  logic fwd;
  logic m_gnt, s_gnt;

  // Response ID is taken from the captured IDs, not from the peripheral.
  logic unused_p_r_id;
  assign unused_p_r_id = ^p_r_id_i;

  // wdata only matters for writes (wen=0).
  assign fields_equal = (m_addr_i == s_addr_i) && (m_wen_i == s_wen_i) &&
                        (m_be_i == s_be_i) && (m_wen_i || (m_wdata_i == s_wdata_i));

  always_comb begin
    state_d        = state_q;
    skew_d         = skew_q;
    m_granted_d    = m_granted_q;
    s_granted_d    = s_granted_q;
    m_id_d         = m_id_q;
    s_id_d         = s_id_q;
    p_req_d        = p_req_q;
    p_addr_d       = p_addr_q;
    p_wen_d        = p_wen_q;
    p_wdata_d      = p_wdata_q;
    p_be_d         = p_be_q;
    p_id_d         = p_id_q;
    mismatch_event = 1'b0;
    fwd            = 1'b0;
    m_gnt          = 1'b0;
    s_gnt          = 1'b0;

    case (state_q)
      StIdle: begin
        if (!enable_i) begin
          skew_d = '0;
          if (m_req_i) begin
            m_gnt = 1'b1;
            fwd   = 1'b1;
          end
        end else if (m_req_i && s_req_i) begin
          skew_d = '0;
          m_gnt  = 1'b1;
          s_gnt  = 1'b1;
          if (fields_equal) begin
            fwd = 1'b1;
          end else begin
            mismatch_event = 1'b1;
          end
        end else if (m_req_i || s_req_i) begin
          if (skew_q == SkewW'(SKEW_MAX)) begin
            // One core has been alone too long: fail only the requester.
            skew_d         = '0;
            mismatch_event = 1'b1;
            m_gnt          = m_req_i;
            s_gnt          = s_req_i;
          end else begin
            skew_d = skew_q + SkewW'(1);
          end
        end else begin
          skew_d = '0;
        end

        if (m_gnt || s_gnt) begin
          m_granted_d = m_gnt;
          s_granted_d = s_gnt;
          if (m_gnt) m_id_d = m_id_i;
          if (s_gnt) s_id_d = s_id_i;
        end

        if (fwd) begin
          state_d   = StIssue;
          p_req_d   = 1'b1;
          p_addr_d  = m_addr_i;
          p_wen_d   = m_wen_i;
          p_wdata_d = m_wdata_i;
          p_be_d    = m_be_i;
          p_id_d    = m_id_i;
        end else if (mismatch_event) begin
          state_d = StErrRsp;
        end
      end
      StIssue: begin
        if (p_gnt_i) begin
          p_req_d = 1'b0;
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (p_r_valid_i) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Clear and a simultaneous divergence leave exactly that one divergence recorded.
  always_comb begin
    error_d = error_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      error_d = 1'b0;
      cnt_d   = '0;
    end
    if (mismatch_event) begin
      error_d = 1'b1;
      if (clear_i) begin
        cnt_d = CNT_WIDTH'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      skew_q      <= '0;
      m_granted_q <= 1'b0;
      s_granted_q <= 1'b0;
      m_id_q      <= '0;
      s_id_q      <= '0;
      p_req_q     <= 1'b0;
      p_addr_q    <= '0;
      p_wen_q     <= 1'b0;
      p_wdata_q   <= '0;
      p_be_q      <= '0;
      p_id_q      <= '0;
      mismatch_q  <= 1'b0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      skew_q      <= (state_d == StIdle) ? skew_d : '0;
      m_granted_q <= m_granted_d;
      s_granted_q <= s_granted_d;
      m_id_q      <= m_id_d;
      s_id_q      <= s_id_d;
      p_req_q     <= p_req_d;
      p_addr_q    <= p_addr_d;
      p_wen_q     <= p_wen_d;
      p_wdata_q   <= p_wdata_d;
      p_be_q      <= p_be_d;
      p_id_q      <= p_id_d;
      mismatch_q  <= mismatch_event;
      error_q     <= error_d;
      cnt_q       <= cnt_d;
    end
  end

  logic rsp_ok, err_rsp, m_rv, s_rv;

  assign rsp_ok  = (state_q == StWaitRsp) && p_r_valid_i;
  assign err_rsp = (state_q == StErrRsp);
  assign m_rv    = m_granted_q && (rsp_ok || err_rsp);
  assign s_rv    = s_granted_q && (rsp_ok || err_rsp);

  assign m_gnt_o     = m_gnt;
  assign s_gnt_o     = s_gnt;
  assign m_r_valid_o = m_rv;
  assign s_r_valid_o = s_rv;
  assign m_r_opc_o   = m_rv && (err_rsp || p_r_opc_i);
  assign s_r_opc_o   = s_rv && (err_rsp || p_r_opc_i);
  assign m_r_rdata_o = (m_rv && rsp_ok) ? p_r_rdata_i : '0;
  assign s_r_rdata_o = (s_rv && rsp_ok) ? p_r_rdata_i : '0;
  assign m_r_id_o    = m_rv ? m_id_q : '0;
  assign s_r_id_o    = s_rv ? s_id_q : '0;

  assign p_req_o   = p_req_q;
  assign p_addr_o  = p_addr_q;
  assign p_wen_o   = p_wen_q;
  assign p_wdata_o = p_wdata_q;
  assign p_be_o    = p_be_q;
  assign p_id_o    = p_id_q;

  assign mismatch_o     = mismatch_q;
  assign error_o        = error_q;
  assign mismatch_cnt_o = cnt_q;

endmodule

// File: tb/tb_lockstep_req_checker.sv
module tb_lockstep_req_checker;

  localparam int unsigned IdW = 5;
  localparam int unsigned CntW = 8;

  logic clk_i = 1'b0;
  logic rst_i, enable_i, clear_i;
  logic m_req_i, m_wen_i, s_req_i, s_wen_i;
  logic [31:0] m_addr_i, m_wdata_i, s_addr_i, s_wdata_i;
  logic [3:0] m_be_i, s_be_i;
  logic [IdW-1:0] m_id_i, s_id_i;
  logic m_gnt_o, m_r_valid_o, m_r_opc_o, s_gnt_o, s_r_valid_o, s_r_opc_o;
  logic [IdW-1:0] m_r_id_o, s_r_id_o, p_id_o, p_r_id_i;
  logic [31:0] m_r_rdata_o, s_r_rdata_o, p_addr_o, p_wdata_o, p_r_rdata_i;
  logic p_req_o, p_wen_o, p_gnt_i, p_r_valid_i, p_r_opc_i;
  logic [3:0] p_be_o;
  logic mismatch_o, error_o;
  logic [CntW-1:0] mismatch_cnt_o;

  int errors = 0;
  int checks = 0;

  lockstep_req_checker #(
    .ID_WIDTH (IdW),
    .SKEW_MAX (2),
    .CNT_WIDTH(CntW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .clear_i       (clear_i),
    .m_req_i       (m_req_i),
    .m_addr_i      (m_addr_i),
    .m_wen_i       (m_wen_i),
    .m_wdata_i     (m_wdata_i),
    .m_be_i        (m_be_i),
    .m_id_i        (m_id_i),
    .m_gnt_o       (m_gnt_o),
    .m_r_valid_o   (m_r_valid_o),
    .m_r_opc_o     (m_r_opc_o),
    .m_r_id_o      (m_r_id_o),
    .m_r_rdata_o   (m_r_rdata_o),
    .s_req_i       (s_req_i),
    .s_addr_i      (s_addr_i),
    .s_wen_i       (s_wen_i),
    .s_wdata_i     (s_wdata_i),
    .s_be_i        (s_be_i),
    .s_id_i        (s_id_i),
    .s_gnt_o       (s_gnt_o),
    .s_r_valid_o   (s_r_valid_o),
    .s_r_opc_o     (s_r_opc_o),
    .s_r_id_o      (s_r_id_o),
    .s_r_rdata_o   (s_r_rdata_o),
    .p_req_o       (p_req_o),
    .p_addr_o      (p_addr_o),
    .p_wen_o       (p_wen_o),
    .p_wdata_o     (p_wdata_o),
    .p_be_o        (p_be_o),
    .p_id_o        (p_id_o),
    .p_gnt_i       (p_gnt_i),
    .p_r_valid_i   (p_r_valid_i),
    .p_r_opc_i     (p_r_opc_i),
    .p_r_id_i      (p_r_id_i),
    .p_r_rdata_i   (p_r_rdata_i),
    .mismatch_o    (mismatch_o),
    .error_o       (error_o),
    .mismatch_cnt_o(mismatch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_drive(input logic req, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [IdW-1:0] id);
    m_req_i = req; m_addr_i = addr; m_wen_i = wen; m_wdata_i = wdata; m_be_i = 4'hF;
    m_id_i = id;
  endtask

  task automatic s_drive(input logic req, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [IdW-1:0] id);
    s_req_i = req; s_addr_i = addr; s_wen_i = wen; s_wdata_i = wdata; s_be_i = 4'hF;
    s_id_i = id;
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0;
    m_drive(1'b0, 32'h0, 1'b1, 32'h0, '0);
    s_drive(1'b0, 32'h0, 1'b1, 32'h0, '0);
    p_gnt_i = 1'b0; p_r_valid_i = 1'b0; p_r_opc_i = 1'b0; p_r_id_i = '0; p_r_rdata_i = '0;
    tick();
    tick();

    // Reset state
    chk("rst_p_req", 32'(p_req_o), 32'd0);
    chk("rst_m_gnt", 32'(m_gnt_o), 32'd0);
    chk("rst_s_gnt", 32'(s_gnt_o), 32'd0);
    chk("rst_m_rv", 32'(m_r_valid_o), 32'd0);
    chk("rst_mm", 32'(mismatch_o), 32'd0);
    chk("rst_err", 32'(error_o), 32'd0);
    chk("rst_cnt", 32'(mismatch_cnt_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Lockstep disabled: main write forwarded, shadow ignored
    m_drive(1'b1, 32'h1020_2800, 1'b0, 32'hA5A5_A5A5, 5'd1);
    s_drive(1'b1, 32'h0000_0044, 1'b1, 32'h0, 5'd2);
    #1;
    chk("dis_m_gnt", 32'(m_gnt_o), 32'd1);
    chk("dis_s_gnt", 32'(s_gnt_o), 32'd0);
    tick();
    m_req_i = 1'b0; s_req_i = 1'b0;
    chk("dis_p_req", 32'(p_req_o), 32'd1);
    chk("dis_p_addr", p_addr_o, 32'h1020_2800);
    chk("dis_p_wdata", p_wdata_o, 32'hA5A5_A5A5);
    chk("dis_p_wen", 32'(p_wen_o), 32'd0);
    chk("dis_p_id", 32'(p_id_o), 32'd1);
    chk("dis_m_gnt_drop", 32'(m_gnt_o), 32'd0);
    p_gnt_i = 1'b1;
    tick();
    p_gnt_i = 1'b0; p_r_valid_i = 1'b1; p_r_rdata_i = 32'h1234_5678; p_r_id_i = 5'd9;
    #1;
    chk("dis_p_req_drop", 32'(p_req_o), 32'd0);
    chk("dis_m_rv", 32'(m_r_valid_o), 32'd1);
    chk("dis_m_rdata", m_r_rdata_o, 32'h1234_5678);
    chk("dis_m_rid", 32'(m_r_id_o), 32'd1);
    chk("dis_s_rv", 32'(s_r_valid_o), 32'd0);
    tick();
    p_r_valid_i = 1'b0;
    #1;
    chk("dis_m_rv_drop", 32'(m_r_valid_o), 32'd0);

    // Lockstep: identical reads (wdata differs, must be ignored for reads)
    enable_i = 1'b1;
    m_drive(1'b1, 32'h0000_0200, 1'b1, 32'h1111_1111, 5'd3);
    s_drive(1'b1, 32'h0000_0200, 1'b1, 32'h2222_2222, 5'd7);
    #1;
    chk("rd_m_gnt", 32'(m_gnt_o), 32'd1);
    chk("rd_s_gnt", 32'(s_gnt_o), 32'd1);
    tick();
    m_req_i = 1'b0; s_req_i = 1'b0;
    chk("rd_p_req", 32'(p_req_o), 32'd1);
    chk("rd_p_id", 32'(p_id_o), 32'd3);
    chk("rd_mm", 32'(mismatch_o), 32'd0);
    tick();
    chk("rd_p_req_hold", 32'(p_req_o), 32'd1);
    p_gnt_i = 1'b1;
    tick();
    p_gnt_i = 1'b0; p_r_valid_i = 1'b1; p_r_rdata_i = 32'hCAFE_F00D;
    #1;
    chk("rd_p_req_drop", 32'(p_req_o), 32'd0);
    chk("rd_m_rv", 32'(m_r_valid_o), 32'd1);
    chk("rd_s_rv", 32'(s_r_valid_o), 32'd1);
    chk("rd_m_rdata", m_r_rdata_o, 32'hCAFE_F00D);
    chk("rd_s_rdata", s_r_rdata_o, 32'hCAFE_F00D);
    chk("rd_m_rid", 32'(m_r_id_o), 32'd3);
    chk("rd_s_rid", 32'(s_r_id_o), 32'd7);
    chk("rd_err", 32'(error_o), 32'd0);
    tick();
    p_r_valid_i = 1'b0;

    // Lockstep: writes differing only in wdata
    m_drive(1'b1, 32'h0000_0300, 1'b0, 32'h1, 5'd4);
    s_drive(1'b1, 32'h0000_0300, 1'b0, 32'h2, 5'd5);
    #1;
    chk("wd_m_gnt", 32'(m_gnt_o), 32'd1);
    chk("wd_s_gnt", 32'(s_gnt_o), 32'd1);
    tick();
    m_req_i = 1'b0; s_req_i = 1'b0;
    chk("wd_p_req", 32'(p_req_o), 32'd0);
    chk("wd_mm", 32'(mismatch_o), 32'd1);
    chk("wd_err", 32'(error_o), 32'd1);
    chk("wd_cnt", 32'(mismatch_cnt_o), 32'd1);
    chk("wd_m_rv", 32'(m_r_valid_o), 32'd1);
    chk("wd_s_rv", 32'(s_r_valid_o), 32'd1);
    chk("wd_m_opc", 32'(m_r_opc_o), 32'd1);
    chk("wd_s_opc", 32'(s_r_opc_o), 32'd1);
    chk("wd_m_rdata", m_r_rdata_o, 32'd0);
    chk("wd_m_rid", 32'(m_r_id_o), 32'd4);
    chk("wd_s_rid", 32'(s_r_id_o), 32'd5);
    tick();
    chk("wd_mm_drop", 32'(mismatch_o), 32'd0);
    chk("wd_m_rv_drop", 32'(m_r_valid_o), 32'd0);
    chk("wd_err_sticky", 32'(error_o), 32'd1);

    // Skew: shadow one cycle late is forwarded normally
    m_drive(1'b1, 32'h0000_0400, 1'b1, 32'h0, 5'd2);
    #1;
    chk("sk1_m_gnt_wait", 32'(m_gnt_o), 32'd0);
    tick();
    s_drive(1'b1, 32'h0000_0400, 1'b1, 32'h0, 5'd6);
    #1;
    chk("sk1_m_gnt", 32'(m_gnt_o), 32'd1);
    chk("sk1_s_gnt", 32'(s_gnt_o), 32'd1);
    tick();
    m_req_i = 1'b0; s_req_i = 1'b0;
    chk("sk1_p_req", 32'(p_req_o), 32'd1);
    p_gnt_i = 1'b1;
    tick();
    p_gnt_i = 1'b0; p_r_valid_i = 1'b1; p_r_rdata_i = 32'h0000_0BEE;
    #1;
    chk("sk1_s_rv", 32'(s_r_valid_o), 32'd1);
    chk("sk1_s_rid", 32'(s_r_id_o), 32'd6);
    chk("sk1_cnt", 32'(mismatch_cnt_o), 32'd1);
    tick();
    p_r_valid_i = 1'b0;

    // Skew: shadow three cycles late, main alone gets an error response
    m_drive(1'b1, 32'h0000_0500, 1'b1, 32'h0, 5'd8);
    #1;
    chk("sk3_t0_gnt", 32'(m_gnt_o), 32'd0);
    tick();
    chk("sk3_t1_gnt", 32'(m_gnt_o), 32'd0);
    tick();
    chk("sk3_m_gnt", 32'(m_gnt_o), 32'd1);
    chk("sk3_s_gnt", 32'(s_gnt_o), 32'd0);
    tick();
    m_req_i = 1'b0;
    chk("sk3_mm", 32'(mismatch_o), 32'd1);
    chk("sk3_cnt", 32'(mismatch_cnt_o), 32'd2);
    chk("sk3_m_rv", 32'(m_r_valid_o), 32'd1);
    chk("sk3_m_opc", 32'(m_r_opc_o), 32'd1);
    chk("sk3_m_rid", 32'(m_r_id_o), 32'd8);
    chk("sk3_s_rv", 32'(s_r_valid_o), 32'd0);
    chk("sk3_p_req", 32'(p_req_o), 32'd0);
    tick();

    // Saturation: back-to-back address mismatches, one every two cycles
    m_drive(1'b1, 32'h0000_0600, 1'b1, 32'h0, 5'd1);
    s_drive(1'b1, 32'h0000_0604, 1'b1, 32'h0, 5'd1);
    for (int i = 0; i < 540; i++) tick();
    m_req_i = 1'b0; s_req_i = 1'b0;
    tick();
    tick();
    chk("sat_cnt", 32'(mismatch_cnt_o), 32'hFF);
    chk("sat_err", 32'(error_o), 32'd1);

    // Clear coinciding with a mismatch
    m_drive(1'b1, 32'h0000_0700, 1'b1, 32'h0, 5'd1);
    s_drive(1'b1, 32'h0000_0704, 1'b1, 32'h0, 5'd1);
    clear_i = 1'b1;
    tick();
    m_req_i = 1'b0; s_req_i = 1'b0; clear_i = 1'b0;
    chk("clrmm_cnt", 32'(mismatch_cnt_o), 32'd1);
    chk("clrmm_err", 32'(error_o), 32'd1);
    chk("clrmm_mm", 32'(mismatch_o), 32'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_cnt", 32'(mismatch_cnt_o), 32'd0);
    chk("clr_err", 32'(error_o), 32'd0);

    // Reset while waiting for the response
    enable_i = 1'b0;
    m_drive(1'b1, 32'h0000_0800, 1'b1, 32'h0, 5'd2);
    tick();
    m_req_i = 1'b0;
    p_gnt_i = 1'b1;
    tick();
    p_gnt_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    p_r_valid_i = 1'b1; p_r_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("mrst_p_req", 32'(p_req_o), 32'd0);
    chk("mrst_p_addr", p_addr_o, 32'd0);
    chk("mrst_m_rv", 32'(m_r_valid_o), 32'd0);
    chk("mrst_m_rdata", m_r_rdata_o, 32'd0);
    tick();
    p_r_valid_i = 1'b0;
    m_drive(1'b1, 32'h0000_0900, 1'b1, 32'h0, 5'd3);
    #1;
    chk("post_m_gnt", 32'(m_gnt_o), 32'd1);
    tick();
    m_req_i = 1'b0;
    chk("post_p_req", 32'(p_req_o), 32'd1);
    chk("post_p_addr", p_addr_o, 32'h0000_0900);
    p_gnt_i = 1'b1;
    tick();
    p_gnt_i = 1'b0; p_r_valid_i = 1'b1; p_r_rdata_i = 32'h0000_0055;
    #1;
    chk("post_m_rv", 32'(m_r_valid_o), 32'd1);
    chk("post_m_rdata", m_r_rdata_o, 32'h0000_0055);
    tick();
    p_r_valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
